// File: rtl/ex_mem_tmr_reg.sv
// Triplicated EX/MEM pipeline register with a bitwise majority vote and a saturating fault counter.
// Define EXMEM_TMR_SCRUB_EN to reload every copy with the voted value on stalled cycles.
module ex_mem_tmr_reg #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned REGW  = 5,
  parameter int unsigned CNTW  = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             flush,
  input  logic [WIDTH-1:0] aluout_e,
  input  logic             zero_e,
  input  logic [WIDTH-1:0] writedata_e,
  input  logic [REGW-1:0]  writereg_e,
  input  logic             regwrite_e,
  input  logic             memwrite_e,
  input  logic             memtoreg_e,
  input  logic             inj_en,
  input  logic [1:0]       inj_sel,
  input  logic [WIDTH-1:0] inj_mask,
  input  logic             fault_clr,
  output logic [WIDTH-1:0] aluout_m,
  output logic             zero_m,
  output logic [WIDTH-1:0] writedata_m,
  output logic [REGW-1:0]  writereg_m,
  output logic             regwrite_m,
  output logic             memwrite_m,
  output logic             memtoreg_m,
  output logic             fault_m,
  output logic [CNTW-1:0]  fault_cnt
);

  localparam int unsigned BW = 2 * WIDTH + REGW + 4;

  logic [BW-1:0]   in_b;
  logic [BW-1:0]   vote;
  logic [BW-1:0]   inj_b;
  logic [BW-1:0]   copy_q [3];
  logic [BW-1:0]   copy_d [3];
  logic [CNTW-1:0] cnt_q, cnt_d;

  assign in_b  = {aluout_e, zero_e, writedata_e, writereg_e, regwrite_e, memwrite_e, memtoreg_e};
  // Injection only ever touches the aluout field, which sits at the top of the bundle.
  assign inj_b = {inj_mask, {(BW - WIDTH){1'b0}}};

  assign vote = (copy_q[0] & copy_q[1]) | (copy_q[0] & copy_q[2]) | (copy_q[1] & copy_q[2]);

  assign {aluout_m, zero_m, writedata_m, writereg_m, regwrite_m, memwrite_m, memtoreg_m} = vote;

  assign fault_m   = |((copy_q[0] ^ vote) | (copy_q[1] ^ vote) | (copy_q[2] ^ vote));
  assign fault_cnt = cnt_q;

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      if (flush) begin
        copy_d[i] = '0;
      end else if (en) begin
        copy_d[i] = in_b;
      end else begin
`ifdef EXMEM_TMR_SCRUB_EN
        copy_d[i] = vote;
`else
        copy_d[i] = copy_q[i];
`endif
      end
      // inj_sel == 3 matches no copy.
      if (inj_en && (inj_sel == 2'(i))) begin
        copy_d[i] = copy_d[i] ^ inj_b;
      end
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (fault_clr) begin
      cnt_d = '0;
    end else if (fault_m && (cnt_q != {CNTW{1'b1}})) begin
      cnt_d = cnt_q + CNTW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      copy_q[0] <= '0;
      copy_q[1] <= '0;
      copy_q[2] <= '0;
      cnt_q     <= '0;
    end else begin
      copy_q[0] <= copy_d[0];
      copy_q[1] <= copy_d[1];
      copy_q[2] <= copy_d[2];
      cnt_q     <= cnt_d;
    end
  end

endmodule

// File: tb/tb_ex_mem_tmr_reg.sv
// Self-checking bench for ex_mem_tmr_reg: a good-value-plus-error-mask model checked every cycle,
// directed literal checks, then randomized traffic. Two instances cover CNTW=8 and CNTW=2.
module tb_ex_mem_tmr_reg;

`ifdef EXMEM_TMR_SCRUB_EN
  localparam bit SCRUB = 1'b1;
`else
  localparam bit SCRUB = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        en = 1'b0, flush = 1'b0, zero_e = 1'b0;
  logic        regwrite_e = 1'b0, memwrite_e = 1'b0, memtoreg_e = 1'b0;
  logic        inj_en = 1'b0, fault_clr = 1'b0;
  logic [31:0] aluout_e = '0, writedata_e = '0, inj_mask = '0;
  logic [4:0]  writereg_e = '0;
  logic [1:0]  inj_sel = '0;

  logic [31:0] aluout_m, writedata_m, aluout_m2, writedata_m2;
  logic [4:0]  writereg_m, writereg_m2;
  logic        zero_m, regwrite_m, memwrite_m, memtoreg_m, fault_m;
  logic        zero_m2, regwrite_m2, memwrite_m2, memtoreg_m2, fault_m2;
  logic [7:0]  fault_cnt;
  logic [1:0]  fault_cnt2;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: the intended (good) bundle plus a per-copy XOR error on the aluout field.
  logic [31:0] g_alu = '0, g_wd = '0;
  logic        g_zero = 1'b0, g_rw = 1'b0, g_mw = 1'b0, g_mt = 1'b0;
  logic [4:0]  g_wr = '0;
  logic [31:0] err [3] = '{default: '0};
  int          cnt8 = 0, cnt2 = 0;

  always #5 clk = ~clk;

  ex_mem_tmr_reg dut (
    .clk(clk), .reset(reset), .en(en), .flush(flush),
    .aluout_e(aluout_e), .zero_e(zero_e), .writedata_e(writedata_e), .writereg_e(writereg_e),
    .regwrite_e(regwrite_e), .memwrite_e(memwrite_e), .memtoreg_e(memtoreg_e),
    .inj_en(inj_en), .inj_sel(inj_sel), .inj_mask(inj_mask), .fault_clr(fault_clr),
    .aluout_m(aluout_m), .zero_m(zero_m), .writedata_m(writedata_m), .writereg_m(writereg_m),
    .regwrite_m(regwrite_m), .memwrite_m(memwrite_m), .memtoreg_m(memtoreg_m),
    .fault_m(fault_m), .fault_cnt(fault_cnt)
  );

  ex_mem_tmr_reg #(.CNTW(2)) dut2 (
    .clk(clk), .reset(reset), .en(en), .flush(flush),
    .aluout_e(aluout_e), .zero_e(zero_e), .writedata_e(writedata_e), .writereg_e(writereg_e),
    .regwrite_e(regwrite_e), .memwrite_e(memwrite_e), .memtoreg_e(memtoreg_e),
    .inj_en(inj_en), .inj_sel(inj_sel), .inj_mask(inj_mask), .fault_clr(fault_clr),
    .aluout_m(aluout_m2), .zero_m(zero_m2), .writedata_m(writedata_m2),
    .writereg_m(writereg_m2), .regwrite_m(regwrite_m2), .memwrite_m(memwrite_m2),
    .memtoreg_m(memtoreg_m2), .fault_m(fault_m2), .fault_cnt(fault_cnt2)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Bit is outvoted when at least two copies carry the same error.
  function automatic logic [31:0] err_vote();
    return (err[0] & err[1]) | (err[0] & err[2]) | (err[1] & err[2]);
  endfunction

  // A copy disagrees with the vote somewhere iff the error masks are not all identical.
  function automatic logic model_fault();
    return |((err[0] ^ err[1]) | (err[1] ^ err[2]));
  endfunction

  task automatic model_clear();
    {g_alu, g_zero, g_wd, g_wr, g_rw, g_mw, g_mt} = '0;
    err  = '{default: '0};
    cnt8 = 0;
    cnt2 = 0;
  endtask

  // Advance to the next rising edge, update the model from the sampled inputs, settle.
  task automatic tick();
    logic f;
    @(posedge clk);
    if (reset) begin
      f = model_fault();
      if (fault_clr) begin
        cnt8 = 0;
        cnt2 = 0;
      end else if (f) begin
        if (cnt8 < 255) cnt8++;
        if (cnt2 < 3) cnt2++;
      end
      if (flush) begin
        {g_alu, g_zero, g_wd, g_wr, g_rw, g_mw, g_mt} = '0;
        err = '{default: '0};
      end else if (en) begin
        {g_alu, g_zero, g_wd, g_wr, g_rw, g_mw, g_mt} =
          {aluout_e, zero_e, writedata_e, writereg_e, regwrite_e, memwrite_e, memtoreg_e};
        err = '{default: '0};
      end else if (SCRUB) begin
        g_alu = g_alu ^ err_vote();
        err   = '{default: '0};
      end
      if (inj_en && inj_sel != 2'd3) err[inj_sel] = err[inj_sel] ^ inj_mask;
    end
    #1;
  endtask

  always @(negedge clk) begin
    check("aluout_m", aluout_m, g_alu ^ err_vote());
    check("zero_m", zero_m, g_zero);
    check("writedata_m", writedata_m, g_wd);
    check("writereg_m", writereg_m, g_wr);
    check("ctrl_m", {regwrite_m, memwrite_m, memtoreg_m}, {g_rw, g_mw, g_mt});
    check("fault_m", fault_m, model_fault());
    check("fault_cnt", fault_cnt, cnt8);
    check("aluout_m2", aluout_m2, g_alu ^ err_vote());
    check("fault_m2", fault_m2, model_fault());
    check("fault_cnt2", fault_cnt2, cnt2);
  end

  task automatic clear_inputs();
    {en, flush, zero_e, regwrite_e, memwrite_e, memtoreg_e, inj_en, fault_clr} = '0;
    aluout_e = '0; writedata_e = '0; inj_mask = '0; writereg_e = '0; inj_sel = '0;
  endtask

  task automatic rand_inputs();
    en          = ($urandom_range(99) < 60);
    flush       = ($urandom_range(99) < 5);
    aluout_e    = $urandom();
    writedata_e = $urandom();
    writereg_e  = 5'($urandom());
    zero_e      = 1'($urandom());
    regwrite_e  = 1'($urandom());
    memwrite_e  = 1'($urandom());
    memtoreg_e  = 1'($urandom());
    inj_en      = ($urandom_range(99) < 15);
    inj_sel     = 2'($urandom_range(3));
    inj_mask    = $urandom_range(1) ? (32'h1 << $urandom_range(31)) : $urandom();
    fault_clr   = ($urandom_range(99) < 3);
    if ($urandom_range(99) == 0) begin
      reset = 1'b0;
      model_clear();
    end else begin
      reset = 1'b1;
    end
  endtask

  initial begin
    model_clear();
    // Reset held from t=0 with random inputs.
    rand_inputs();
    reset = 1'b0;
    #1;
    check("rst_aluout", aluout_m, 64'h0);
    check("rst_fault", fault_m, 64'h0);
    check("rst_cnt", fault_cnt, 64'h0);
    tick();
    tick();
    check("rst_hold_aluout", aluout_m, 64'h0);

    clear_inputs();
    reset = 1'b1; en = 1'b1; aluout_e = 32'h0000_0005; regwrite_e = 1'b1;
    tick();
    check("load_aluout", aluout_m, 64'h5);
    check("load_regwrite", regwrite_m, 64'h1);

    flush = 1'b1; aluout_e = 32'hFFFF_FFFF; memwrite_e = 1'b1;
    tick();
    check("flush_aluout", aluout_m, 64'h0);
    check("flush_memwrite", memwrite_m, 64'h0);
    check("flush_regwrite", regwrite_m, 64'h0);

    clear_inputs();
    en = 1'b1; aluout_e = 32'h1234_5678;
    tick();
    check("load2_aluout", aluout_m, 64'h1234_5678);

    en = 1'b0; inj_en = 1'b1; inj_sel = 2'd1; inj_mask = 32'h0000_0001;
    tick();
    check("inj_aluout", aluout_m, 64'h1234_5678);
    check("inj_fault", fault_m, 64'h1);
    check("inj_cnt", fault_cnt, 64'h0);

    inj_en = 1'b0;
    tick();
    check("stall1_cnt", fault_cnt, 64'h1);
    check("stall1_fault", fault_m, SCRUB ? 64'h0 : 64'h1);
    repeat (5) tick();
    check("stall6_cnt", fault_cnt, SCRUB ? 64'h1 : 64'h6);
    check("stall6_cnt2_sat", fault_cnt2, SCRUB ? 64'h1 : 64'h3);
    check("stall6_aluout", aluout_m, 64'h1234_5678);

    fault_clr = 1'b1;
    tick();
    check("clr_cnt", fault_cnt, 64'h0);
    check("clr_cnt2", fault_cnt2, 64'h0);

    fault_clr = 1'b0; en = 1'b1; aluout_e = 32'hA5A5_A5A5;
    tick();
    check("reload_aluout", aluout_m, 64'hA5A5_A5A5);
    check("reload_fault", fault_m, 64'h0);
    check("reload_cnt", fault_cnt, SCRUB ? 64'h0 : 64'h1);

    en = 1'b0; inj_en = 1'b1; inj_sel = 2'd3; inj_mask = 32'hFFFF_FFFF;
    tick();
    check("sel3_fault", fault_m, 64'h0);
    check("sel3_cnt", fault_cnt, SCRUB ? 64'h0 : 64'h1);

    en = 1'b1; aluout_e = 32'h0F0F_0F0F; inj_sel = 2'd2; inj_mask = 32'hF000_0000;
    tick();
    check("inj_load_aluout", aluout_m, 64'h0F0F_0F0F);
    check("inj_load_fault", fault_m, 64'h1);

    en = 1'b0; inj_sel = 2'd0; inj_mask = 32'h0000_0080;
    tick();
    check("pre_rst_fault", fault_m, 64'h1);
    reset = 1'b0;
    model_clear();
    #1;
    check("mid_rst_aluout", aluout_m, 64'h0);
    check("mid_rst_fault", fault_m, 64'h0);
    check("mid_rst_cnt", fault_cnt, 64'h0);
    check("mid_rst_cnt2", fault_cnt2, 64'h0);
    inj_en = 1'b0;
    tick();
    reset = 1'b1;

    repeat (3000) begin
      rand_inputs();
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ex_mem_tmr_reg.md
# ex_mem_tmr_reg

Triplicated EX/MEM pipeline register directly downstream of the voted ALU. It captures the ALU result and zero flag with the store data, destination register and memory/writeback controls. Its three storage copies are majority-voted on output, so a single upset in any copy never reaches the memory stage. Mismatches between copies are flagged and counted, and can optionally be scrubbed while the pipeline is stalled.

## Interface
- WIDTH, 32, datapath width of ALU result and store data
- REGW, 5, destination register index width
- CNTW, 8, fault counter width
- clk  in  1  pipeline clock, all state on rising edge
- reset  in  1  asynchronous, active-low; clears all three copies and counter
- en  in  1  load enable; 0 = stall (hold or scrub)
- flush  in  1  load bubble (all fields 0); overrides en
- aluout_e  in  WIDTH  ALU result
- zero_e  in  1  ALU zero flag
- writedata_e  in  WIDTH  store data
- writereg_e  in  REGW  destination register
- regwrite_e, memwrite_e, memtoreg_e  in  1 each  control bits
- inj_en  in  1  fault injection strobe (test only; tie 0 in product)
- inj_sel  in  2  target copy 0..2; 3 = no copy
- inj_mask  in  WIDTH  XOR mask applied to target copy's aluout field
- fault_clr  in  1  synchronous counter clear
- aluout_m, zero_m, writedata_m, writereg_m, regwrite_m, memwrite_m, memtoreg_m  out  as inputs  voted register outputs
- fault_m  out  1  combinational: any copy differs from voted value
- fault_cnt  out  CNTW  saturating count of cycles with fault_m=1

## Operation
- Bundle B = {aluout, zero, writedata, writereg, regwrite, memwrite, memtoreg}; width 2*WIDTH+REGW+4 (73 by default). Copies c0, c1, c2 each hold a full B.
- Vote v = (c0&c1)|(c0&c2)|(c1&c2), bitwise. All *_m outputs are fields of v.
- Next-state per copy, in priority order:
  - reset low: 0.
  - flush: 0, which is a bubble with all controls deasserted.
  - en: input bundle.
  - Otherwise: hold own value, or load v when scrubbing is compiled in.
- Injection is applied after the selection above, on the same edge. If inj_en=1 and inj_sel<3, the aluout field of copy inj_sel gets XOR inj_mask. inj_sel=3 does nothing.
- fault_m = |((c0^v)|(c1^v)|(c2^v)).
- fault_cnt on each edge:
  - fault_clr=1: clear to 0. Clear has priority over increment.
  - else fault_m=1 and fault_cnt not all-ones: increment by 1.
  - Saturates at 2^CNTW-1 and does not wrap.
- Two copies corrupted identically in the same bit outvote the good copy. This is undetected and outside the guarantee.

## Timing
- Latency is 1 cycle. Inputs sampled at edge N appear on *_m after edge N.
- Reset is asynchronous. Every output is 0 immediately on assertion: *_m=0, fault_m=0, fault_cnt=0. Release is synchronous to the next edge.
- Reset mid-stall or mid-injection discards all state, including the counter.
- flush and en both 1: flush wins and a bubble is loaded.
- inj_en together with en: the new input is loaded, then the mask is XORed into the target copy. The voted output still equals the new input, and fault_m=1 from that edge.
- Without scrubbing, a fault persists until the next en or flush load overwrites it. fault_cnt increments every cycle it persists.

## Configuration
- EXMEM_TMR_SCRUB_EN defined:
  - Stalled cycles (en=0, flush=0) reload all copies with v.
  - A single-copy fault is cleared one edge after it appears.
  - fault_m then drops, and fault_cnt records exactly 1 per injected fault.
- EXMEM_TMR_SCRUB_EN undefined:
  - Stalled copies hold their own value.
  - Faults persist through stalls.

## Test plan
- Reset low at t=0 with random inputs -> all *_m=0, fault_m=0, fault_cnt=0. Release reset, en=1, aluout_e=0x0000_0005, regwrite_e=1 -> next cycle aluout_m=0x5, regwrite_m=1.
- en=1, flush=1, aluout_e=0xFFFF_FFFF, memwrite_e=1 -> aluout_m=0, memwrite_m=0, regwrite_m=0.
- Load 0x1234_5678, then en=0 with inj_en=1, inj_sel=1, inj_mask=0x0000_0001:
  - aluout_m stays 0x1234_5678 and fault_m=1.
  - Scrub defined: fault_m=0 after one more stalled edge, fault_cnt=1.
  - Scrub undefined: fault_cnt counts 1,2,3… across stall cycles until en=1 loads new data.
- inj_sel=3 with inj_en=1, inj_mask=0xFFFF_FFFF -> fault_m stays 0, fault_cnt unchanged.
- CNTW=2, persistent fault with scrub undefined for 6 cycles -> fault_cnt saturates at 3. fault_clr=1 -> 0 next edge. Assert reset mid-fault -> counter and outputs 0 immediately.
